// File: rtl/hpu_lmbank_arb.sv
// rtl/hpu_lmbank_arb.sv - dual-port local-memory bank array with per-bank arbitration
//
// Purpose: NBANK single-port banks shared by a read-only matrix port and a
// valid/ready DMA port. The matrix port wins bank conflicts until the DMA side
// has lost STARVE_MAX consecutive cycles. DMA reads are credit-limited against
// a small response FIFO, so read data is never dropped.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   mtx_valid_i/ready_o     matrix request handshake
//   mtx_bcast_i             read mtx_row_i in every bank
//   mtx_bank_i, mtx_row_i   matrix target
//   mtx_rvalid_o            matrix data valid (two cycles after accept)
//   mtx_rdata_o             single-bank row data
//   mtx_bcast_rdata_o       all banks' row data, bank b at [b*WORD_WTH +: WORD_WTH]
//   dma_valid_i/ready_o     DMA command handshake
//   dma_we_i                1 = write, 0 = read
//   dma_addr_i              {row, bank, slice}, slice in the LSBs
//   dma_wdata_i/wstrb_i     write data and byte strobes
//   dma_rvalid_o/rready_i   DMA read-response handshake
//   dma_rdata_o             DMA read-response data
module hpu_lmbank_arb #(
    parameter int NBANK      = 8,
    parameter int BANK_DEPTH = 512,
    parameter int WORD_WTH   = 512,
    parameter int BUS_WTH    = 256,
    parameter int STARVE_MAX = 4,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  mtx_valid_i,
    output logic                                  mtx_ready_o,
    input  logic                                  mtx_bcast_i,
    input  logic [$clog2(NBANK)-1:0]              mtx_bank_i,
    input  logic [$clog2(BANK_DEPTH)-1:0]         mtx_row_i,
    output logic                                  mtx_rvalid_o,
    output logic [WORD_WTH-1:0]                   mtx_rdata_o,
    output logic [NBANK*WORD_WTH-1:0]             mtx_bcast_rdata_o,
    input  logic                                  dma_valid_i,
    output logic                                  dma_ready_o,
    input  logic                                  dma_we_i,
    input  logic [$clog2(BANK_DEPTH)+$clog2(NBANK)+$clog2(WORD_WTH/BUS_WTH)-1:0] dma_addr_i,
    input  logic [BUS_WTH-1:0]                    dma_wdata_i,
    input  logic [BUS_WTH/8-1:0]                  dma_wstrb_i,
    output logic                                  dma_rvalid_o,
    input  logic                                  dma_rready_i,
    output logic [BUS_WTH-1:0]                    dma_rdata_o
);
    localparam int NSLICE = WORD_WTH / BUS_WTH;
    localparam int BW     = $clog2(NBANK);
    localparam int RW     = $clog2(BANK_DEPTH);
    localparam int SLW    = $clog2(NSLICE);
    localparam int SLI    = (SLW > 0) ? SLW : 1;
    localparam int NBYTE  = BUS_WTH / 8;
    localparam int SCW    = $clog2(STARVE_MAX + 1);
    localparam int PW     = $clog2(RSP_DEPTH);
    localparam int CW     = $clog2(RSP_DEPTH + 1);

    // DMA address fields
    logic [BW-1:0]  dma_bank;
    logic [RW-1:0]  dma_row;
    logic [SLI-1:0] dma_slice;

    assign dma_bank  = BW'(dma_addr_i >> SLW);
    assign dma_row   = RW'(dma_addr_i >> (SLW + BW));
    assign dma_slice = (SLW == 0) ? '0 : SLI'(dma_addr_i);

    // state
    logic [SCW-1:0]                    starve_q, starve_d;
    logic                              mv1_q, mv1_d;
    logic [BW-1:0]                     mbank1_q, mbank1_d;
    logic                              dv1_q, dv1_d;
    logic [BW-1:0]                     dbank1_q, dbank1_d;
    logic [SLI-1:0]                    dslice1_q, dslice1_d;
    logic                              mrvalid_q, mrvalid_d;
    logic [WORD_WTH-1:0]               mrdata_q, mrdata_d;
    logic [NBANK-1:0][WORD_WTH-1:0]    mbrdata_q, mbrdata_d;
    logic [PW-1:0]                     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]                     cnt_q, cnt_d;
    logic [BUS_WTH-1:0]                fifo_mem [RSP_DEPTH];

    logic                              conflict, dma_wins, credit_ok;
    logic                              mtx_acc, dma_acc, push, pop;
    logic [BUS_WTH-1:0]                push_data;
    logic [NBANK-1:0][WORD_WTH-1:0]    bank_rdata;

    always_comb begin
        conflict  = mtx_valid_i & dma_valid_i & (mtx_bcast_i | (mtx_bank_i == dma_bank));
        dma_wins  = conflict & (starve_q == SCW'(STARVE_MAX));
        // The in-flight read (accepted last cycle) already owns a FIFO slot.
        credit_ok = ((CW+1)'(cnt_q) + (CW+1)'(dv1_q)) < (CW+1)'(RSP_DEPTH);
        mtx_acc   = ~rst_i & mtx_valid_i & ~dma_wins;
        dma_acc   = ~rst_i & dma_valid_i & (~conflict | dma_wins) & (dma_we_i | credit_ok);
    end

    assign mtx_ready_o = mtx_acc;
    assign dma_ready_o = dma_acc;

    // banks: matrix and DMA never hit the same bank in one cycle
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic [WORD_WTH-1:0] mem [BANK_DEPTH];
        logic [WORD_WTH-1:0] rdata_q;
        logic                mhit, dwr;
        logic [RW-1:0]       raddr;

        assign mhit  = mtx_acc & (mtx_bcast_i | (mtx_bank_i == BW'(b)));
        assign dwr   = dma_acc & dma_we_i & (dma_bank == BW'(b));
        assign raddr = mhit ? mtx_row_i : dma_row;

        always_ff @(posedge clk_i) begin
            if (dwr) begin
                for (int k = 0; k < NBYTE; k++) begin
                    if (dma_wstrb_i[k]) begin
                        mem[dma_row][int'(dma_slice)*BUS_WTH + 8*k +: 8] <= dma_wdata_i[8*k +: 8];
                    end
                end
            end
            rdata_q <= mem[raddr];
        end

        assign bank_rdata[b] = rdata_q;
    end

    always_comb begin
        mv1_d     = mtx_acc;
        mbank1_d  = mtx_bank_i;
        dv1_d     = dma_acc & ~dma_we_i;
        dbank1_d  = dma_bank;
        dslice1_d = dma_slice;
        mrvalid_d = mv1_q;
        mrdata_d  = mrdata_q;
        mbrdata_d = mbrdata_q;
        if (mv1_q) begin
            mrdata_d  = bank_rdata[mbank1_q];
            mbrdata_d = bank_rdata;
        end

        push      = dv1_q;
        push_data = bank_rdata[dbank1_q][int'(dslice1_q)*BUS_WTH +: BUS_WTH];
        pop       = (cnt_q != '0) & dma_rready_i;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        if (push) wptr_d = (wptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
        if (pop)  rptr_d = (rptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
        cnt_d = cnt_q + CW'(push) - CW'(pop);

        starve_d = starve_q;
        if (dma_acc) begin
            starve_d = '0;
        end else if (dma_valid_i && conflict && !dma_wins) begin
            starve_d = starve_q + SCW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q  <= '0;
            mv1_q     <= 1'b0;
            mbank1_q  <= '0;
            dv1_q     <= 1'b0;
            dbank1_q  <= '0;
            dslice1_q <= '0;
            mrvalid_q <= 1'b0;
            mrdata_q  <= '0;
            mbrdata_q <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            starve_q  <= starve_d;
            mv1_q     <= mv1_d;
            mbank1_q  <= mbank1_d;
            dv1_q     <= dv1_d;
            dbank1_q  <= dbank1_d;
            dslice1_q <= dslice1_d;
            mrvalid_q <= mrvalid_d;
            mrdata_q  <= mrdata_d;
            mbrdata_q <= mbrdata_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wptr_q] <= push_data;
    end

    assign mtx_rvalid_o      = mrvalid_q;
    assign mtx_rdata_o       = mrdata_q;
    assign mtx_bcast_rdata_o = mbrdata_q;
    assign dma_rvalid_o      = (cnt_q != '0);
    // Gated so the response data reads 0 whenever no response is pending.
    assign dma_rdata_o       = dma_rvalid_o ? fifo_mem[rptr_q] : '0;

endmodule
